// File: rtl/rle_word_packer_if.sv
// Load-side handshake bundle between the field source/consumer and rle_word_packer.
// The shared 32-bit data bus stays a plain inout port on the packer.
interface rle_word_packer_if #(
    parameter int FIELD_W = 16
);
    logic               field_valid;
    logic [FIELD_W-1:0] field_data;
    logic [4:0]         field_len;
    logic               field_ready;
    logic               flush;
    logic               interrupt;
    logic               load_process;
    logic               done_cpu;
    logic               busy;

    modport master (
        output field_valid, field_data, field_len, flush, done_cpu,
        input  field_ready, interrupt, load_process, busy
    );

    modport slave (
        input  field_valid, field_data, field_len, flush, done_cpu,
        output field_ready, interrupt, load_process, busy
    );
endinterface

// File: rtl/rle_word_packer.sv
// Run-length encodes variable-length bit fields into 32-bit words of {bit, run[2:0]} nibbles
// and hands each word to the IO decoder. Optional counters under `RLE_STATS_EN.
module rle_word_packer #(
    parameter int FIELD_W = 16,
    parameter int RUN_MAX = 7
) (
    input  logic              clk,
    input  logic              rst,
    rle_word_packer_if.slave  bus,
    inout  wire  [31:0]       data
`ifdef RLE_STATS_EN
    ,
    output logic [15:0]       words_sent,
    output logic [15:0]       bits_sent
`endif
);

    typedef enum logic [2:0] {
        IDLE, SHIFT, SEND, WAIT_ACK, FLUSH, START, DONE
    } state_t;

    state_t             state, next_state, ret_state, ret_next;
    logic [FIELD_W-1:0] sreg;
    logic [4:0]         bits_left;
    logic               cur;
    logic [2:0]         run_len;
    logic [3:0]         nib_cnt;
    logic [31:0]        word_buf;
    logic               credit;
    logic               loading;

    logic               bit_in, accept, consume, emit, clear_run, save_ret, full;
    logic [3:0]         nib;

    assign bit_in = sreg[FIELD_W-1];
    assign full   = emit && (nib_cnt == 4'd7);

    assign bus.field_ready  = (state == IDLE);
    assign bus.busy         = (state != IDLE) && (state != DONE);
    assign bus.interrupt    = (state == SEND) || (state == START);
    assign bus.load_process = (state == SEND) ||
                              (loading && (state != START) && (state != DONE));
    assign data = (state == SEND) ? word_buf : 32'hzzzz_zzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A bit that completes the eighth nibble is consumed first; the word then goes out
    // before anything else, and WAIT_ACK brings us back to wherever we left off.
    always_comb begin
        next_state = state;
        ret_next   = IDLE;
        save_ret   = 1'b0;
        accept     = 1'b0;
        consume    = 1'b0;
        emit       = 1'b0;
        clear_run  = 1'b0;
        nib        = {cur, run_len};
        case (state)
            IDLE: begin
                if (bus.field_valid) begin
                    accept = 1'b1;
                    if (bus.field_len != 5'd0) next_state = SHIFT;
                end else if (bus.flush) begin
                    next_state = FLUSH;
                end
            end
            SHIFT: begin
                consume = 1'b1;
                emit    = (run_len != 3'd0) &&
                          !((bit_in == cur) && (run_len < 3'(RUN_MAX)));
                if (full) begin
                    next_state = credit ? SEND : WAIT_ACK;
                    save_ret   = 1'b1;
                    ret_next   = (bits_left == 5'd1) ? IDLE : SHIFT;
                end else if (bits_left == 5'd1) begin
                    next_state = IDLE;
                end
            end
            SEND:     next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (credit) next_state = (nib_cnt == 4'd8) ? SEND : ret_state;
            end
            FLUSH: begin
                if (run_len != 3'd0) begin
                    emit      = 1'b1;
                    clear_run = 1'b1;
                end else if (nib_cnt != 4'd0) begin
                    emit = 1'b1;
                    nib  = 4'b0000;
                end else if (credit) begin
                    next_state = START;
                end
                if (full) begin
                    next_state = credit ? SEND : WAIT_ACK;
                    save_ret   = 1'b1;
                    ret_next   = FLUSH;
                end
            end
            START:   next_state = DONE;
            default: next_state = DONE;
        endcase
    end

    // done_cpu seen during SEND already counts toward the next word's credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            bits_left <= '0;
            cur       <= 1'b0;
            run_len   <= '0;
            nib_cnt   <= '0;
            word_buf  <= '0;
            credit    <= 1'b1;
            loading   <= 1'b0;
            ret_state <= IDLE;
        end else begin
            if (accept) begin
                sreg      <= bus.field_data << (5'(FIELD_W) - bus.field_len);
                bits_left <= bus.field_len;
                loading   <= 1'b1;
            end
            if (consume) begin
                sreg      <= sreg << 1;
                bits_left <= bits_left - 5'd1;
                cur       <= bit_in;
                if (run_len == 3'd0 || emit) run_len <= 3'd1;
                else                         run_len <= run_len + 3'd1;
            end
            if (clear_run) run_len <= 3'd0;
            if (emit) begin
                word_buf <= {word_buf[27:0], nib};
                nib_cnt  <= nib_cnt + 4'd1;
            end
            if (save_ret) ret_state <= ret_next;
            if (state == SEND) begin
                nib_cnt <= 4'd0;
                credit  <= bus.done_cpu;
            end else if (bus.done_cpu) begin
                credit <= 1'b1;
            end
        end
    end

`ifdef RLE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_sent <= '0;
            bits_sent  <= '0;
        end else begin
            if (state == SEND && words_sent != 16'hFFFF) words_sent <= words_sent + 16'd1;
            if (consume && bits_sent != 16'hFFFF)        bits_sent  <= bits_sent + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rle_word_packer.sv
// Scoreboard bench for rle_word_packer: expected words are queued when fields are driven
// and popped by a negedge monitor whenever the packer presents a word.
module tb_rle_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] data;

    rle_word_packer_if bus();

`ifdef RLE_STATS_EN
    logic [15:0] words_sent, bits_sent;
`endif

    rle_word_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .data       (data)
`ifdef RLE_STATS_EN
        ,
        .words_sent (words_sent),
        .bits_sent  (bits_sent)
`endif
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          words_seen = 0;
    int          start_cnt  = 0;
    logic [31:0] exp_q[$];
    logic        auto_ack   = 1'b0;
    logic        manual_ack = 1'b0;

    // Word strobes are checked against the scoreboard; START strobes are only counted.
    always @(negedge clk) begin : monitor
        logic        ack;
        logic [31:0] exp_word;
        ack = manual_ack;
        if (!rst && bus.interrupt === 1'b1) begin
            if (bus.load_process === 1'b1) begin
                words_seen++;
                compared++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL word_unexpected: got %h, expected no word", data);
                    mismatched++;
                end else begin
                    exp_word = exp_q.pop_front();
                    if (data !== exp_word) begin
                        $display("[TB] FAIL word_data: got %h, expected %h", data, exp_word);
                        mismatched++;
                    end
                end
                if (auto_ack) ack = 1'b1;
            end else begin
                start_cnt++;
            end
        end
        bus.done_cpu = ack;
    end

    task automatic do_reset;
        rst = 1'b1;
        bus.field_valid = 1'b0;
        bus.field_data  = '0;
        bus.field_len   = '0;
        bus.flush       = 1'b0;
        auto_ack   = 1'b0;
        manual_ack = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        words_seen = 0;
        start_cnt  = 0;
        rst = 1'b0;
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        @(negedge clk); #2;
        while (!bus.field_ready && n < 400) begin
            @(negedge clk); #2;
            n++;
        end
        compared++;
        if (!bus.field_ready) begin
            $display("[TB] FAIL ready_timeout: field_ready %b, expected 1", bus.field_ready);
            mismatched++;
        end
    endtask

    task automatic send_field(input logic [15:0] d, input logic [4:0] l);
        wait_ready();
        bus.field_valid = 1'b1;
        bus.field_data  = d;
        bus.field_len   = l;
        @(negedge clk); #2;
        bus.field_valid = 1'b0;
    endtask

    task automatic do_flush;
        wait_ready();
        bus.flush = 1'b1;
        @(negedge clk); #2;
        bus.flush = 1'b0;
    endtask

    task automatic pulse_ack;
        manual_ack = 1'b1;
        @(negedge clk); #2;
        manual_ack = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((bus.busy || bus.field_ready) && n < 400) begin
            @(negedge clk); #2;
            n++;
        end
        compared++;
        if (bus.busy !== 1'b0 || bus.field_ready !== 1'b0) begin
            $display("[TB] FAIL %s_done: busy %b ready %b, expected 0 0", name, bus.busy, bus.field_ready);
            mismatched++;
        end
        compared++;
        if (start_cnt != 1 || bus.load_process !== 1'b0 || bus.interrupt !== 1'b0) begin
            $display("[TB] FAIL %s_start: starts %0d lp %b irq %b, expected 1 0 0",
                     name, start_cnt, bus.load_process, bus.interrupt);
            mismatched++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL %s_pending: %0d words outstanding, expected 0", name, exp_q.size());
            mismatched++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.field_valid = 1'b0;
        bus.flush       = 1'b0;
        @(negedge clk); #2;
        compared++;
        if (bus.field_ready !== 1'b1 || bus.interrupt !== 1'b0 ||
            bus.load_process !== 1'b0 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL reset_outputs: ready %b irq %b lp %b busy %b, expected 1 0 0 0",
                     bus.field_ready, bus.interrupt, bus.load_process, bus.busy);
            mismatched++;
        end
        do_reset();
        @(negedge clk); #2;
        compared++;
        if (bus.field_ready !== 1'b1 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL reset_release: ready %b busy %b, expected 1 0", bus.field_ready, bus.busy);
            mismatched++;
        end
    endtask

    task automatic test_basic;
        do_reset();
        auto_ack = 1'b1;
        exp_q.push_back(32'h3919_0000);
        send_field(16'h0005, 5'd6);
        compared++;
        if (bus.load_process !== 1'b1) begin
            $display("[TB] FAIL basic_loading: load_process %b, expected 1", bus.load_process);
            mismatched++;
        end
        do_flush();
        wait_done("basic");
    endtask

    task automatic test_zeros;
        do_reset();
        auto_ack = 1'b1;
        exp_q.push_back(32'h7720_0000);
        send_field(16'h0000, 5'd16);
        do_flush();
        wait_done("zeros");
    endtask

    task automatic test_back_to_back;
        do_reset();
        exp_q.push_back(32'h1919_1919);
        for (int i = 0; i < 9; i++) send_field(16'(i % 2), 5'd1);
        repeat (6) begin @(negedge clk); #2; end
        compared++;
        if (words_seen != 1 || bus.busy !== 1'b1 || bus.field_ready !== 1'b0) begin
            $display("[TB] FAIL stall_wait: words %0d busy %b ready %b, expected 1 1 0",
                     words_seen, bus.busy, bus.field_ready);
            mismatched++;
        end
        pulse_ack();
        auto_ack = 1'b1;
        exp_q.push_back(32'h1000_0000);
        do_flush();
        wait_done("stall");
        compared++;
        if (words_seen != 2) begin
            $display("[TB] FAIL stall_words: got %0d words, expected 2", words_seen);
            mismatched++;
        end
    endtask

    task automatic test_boundary;
        do_reset();
        auto_ack = 1'b1;
        exp_q.push_back(32'hFFFF_C000);
        send_field(16'hFFFF, 5'd16);
        send_field(16'hFFFF, 5'd16);
        do_flush();
        wait_done("boundary");
    endtask

    task automatic test_reset_mid_send;
        int  n;
        bit  seen;
        do_reset();
        exp_q.push_back(32'h1919_1919);
        for (int i = 0; i < 9; i++) send_field(16'(i % 2), 5'd1);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            if (bus.interrupt === 1'b1 && bus.load_process === 1'b1) seen = 1'b1;
            else begin @(negedge clk); #2; n++; end
        end
        rst = 1'b1;
        #1;
        compared++;
        if (!seen || bus.interrupt !== 1'b0 || data === 32'h1919_1919 ||
            bus.field_ready !== 1'b1 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL rst_in_send: seen %b irq %b data %h ready %b busy %b, expected 1 0 released 1 0",
                     seen, bus.interrupt, data, bus.field_ready, bus.busy);
            mismatched++;
        end
        do_reset();
        exp_q.push_back(32'h3919_0000);
        send_field(16'h0005, 5'd6);
        do_flush();
        n = 0;
        while (words_seen < 1 && n < 100) begin @(negedge clk); #2; n++; end
        repeat (4) begin @(negedge clk); #2; end
        compared++;
        if (words_seen != 1 || start_cnt != 0 || bus.busy !== 1'b1) begin
            $display("[TB] FAIL rst_credit: words %0d starts %0d busy %b, expected 1 0 1",
                     words_seen, start_cnt, bus.busy);
            mismatched++;
        end
        pulse_ack();
        wait_done("rst_resume");
    endtask

    task automatic test_empty_flush;
        do_reset();
        do_flush();
        compared++;
        if (start_cnt != 0 || bus.busy !== 1'b1) begin
            $display("[TB] FAIL empty_flush_state: starts %0d busy %b, expected 0 1", start_cnt, bus.busy);
            mismatched++;
        end
        @(negedge clk); #2;
        compared++;
        if (start_cnt != 1) begin
            $display("[TB] FAIL empty_start: starts %0d, expected 1", start_cnt);
            mismatched++;
        end
        @(negedge clk); #2;
        compared++;
        if (bus.busy !== 1'b0 || bus.field_ready !== 1'b0 || words_seen != 0 || bus.interrupt !== 1'b0) begin
            $display("[TB] FAIL empty_done: busy %b ready %b words %0d irq %b, expected 0 0 0 0",
                     bus.busy, bus.field_ready, words_seen, bus.interrupt);
            mismatched++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.done_cpu = 1'b0;
        test_reset();
        test_basic();
        test_zeros();
        test_back_to_back();
        test_boundary();
        test_reset_mid_send();
        test_empty_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
